// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   DM_AW / DM_DW : default DM word-address and data widths (11-bit word
//                   address as used by the AHB host controller)
//   WAIT_W        : width of the AHB bounded-wait counter
//   arb_state_t   : AHB-side transaction state
package dm_port_arbiter_pkg;

  localparam int DM_AW  = 11;
  localparam int DM_DW  = 32;
  localparam int WAIT_W = 4;

  localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    AHB_RD  = 2'd1,
    AHB_ACK = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of the CPU load/store port, the AHB host port and the DM port
// around the data-memory arbiter.
//   cpu_*        : CPU request (req/we/addr/wdata) and response (stall/rvalid/rdata)
//   ahb_*        : AHB host request (req/we/addr/wdata) and response (ack/rdata)
//   mem_*        : single-port synchronous-read DM (addr/din/wen out, dout in)
//   conflict_cnt : contention statistic
// Modports: slave = arbiter view, master = surrounding system view.
interface dm_port_arbiter_if
  import dm_port_arbiter_pkg::*;
#(
  parameter int AW = DM_AW,
  parameter int DW = DM_DW
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          ahb_req;
  logic          ahb_we;
  logic [AW-1:0] ahb_addr;
  logic [DW-1:0] ahb_wdata;
  logic          ahb_ack;
  logic [DW-1:0] ahb_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_wen;
  logic [DW-1:0] mem_dout;

  logic [15:0]   conflict_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  ahb_req, ahb_we, ahb_addr, ahb_wdata,
    output ahb_ack, ahb_rdata,
    output mem_addr, mem_din, mem_wen,
    input  mem_dout,
    output conflict_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output ahb_req, ahb_we, ahb_addr, ahb_wdata,
    input  ahb_ack, ahb_rdata,
    input  mem_addr, mem_din, mem_wen,
    output mem_dout,
    input  conflict_cnt
  );

endinterface

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares the single-port DM between the CPU
// load/store unit and the AHB host path. CPU has default priority; the AHB
// side is forced ahead after MAX_WAIT consecutive denied cycles.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : dm_port_arbiter_if.slave (CPU, AHB and DM signals)
// Build option: define DM_ARB_CONFLICT_CNT_EN to enable the contention
// counter on bus.conflict_cnt; otherwise it is tied to zero.
//
// state   | meaning
// IDLE    | no AHB transaction in flight, AHB may be granted
// AHB_RD  | AHB read data on mem_dout, ack pulsed this cycle
// AHB_ACK | write ack cycle, or read cooldown while requester drops ahb_req
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int AW       = DM_AW,
  parameter int DW       = DM_DW,
  parameter int MAX_WAIT = 4
) (
  input logic              clk,
  input logic              rst,
  dm_port_arbiter_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              ahb_free;
  logic              gnt_ahb;
  logic              gnt_cpu;
  logic [AW-1:0]     last_addr;
  logic [DW-1:0]     last_din;
  logic [DW-1:0]     ahb_rdata_q;
  logic [DW-1:0]     cpu_rdata_q;
  logic              ahb_ack_q;
  logic              cpu_rvalid_q;

  // A held ahb_req must not be regranted while its transaction is in flight.
  assign ahb_free = (state == IDLE);
  assign gnt_ahb  = bus.ahb_req & ahb_free & (~bus.cpu_req | (wait_cnt >= WAIT_LIM));
  assign gnt_cpu  = bus.cpu_req & ~gnt_ahb;

  // Address/data hold the last granted values so an idle port does not toggle.
  always_comb begin
    bus.mem_addr = last_addr;
    bus.mem_din  = last_din;
    bus.mem_wen  = 1'b0;
    if (gnt_ahb) begin
      bus.mem_addr = bus.ahb_addr;
      bus.mem_din  = bus.ahb_wdata;
      bus.mem_wen  = bus.ahb_we;
    end else if (gnt_cpu) begin
      bus.mem_addr = bus.cpu_addr;
      bus.mem_din  = bus.cpu_wdata;
      bus.mem_wen  = bus.cpu_we;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.ahb_ack    = ahb_ack_q;
    bus.ahb_rdata  = ahb_rdata_q;
    bus.cpu_stall  = bus.cpu_req & ~gnt_cpu;
    bus.cpu_rvalid = cpu_rvalid_q;
    bus.cpu_rdata  = cpu_rvalid_q ? bus.mem_dout : cpu_rdata_q;
    unique case (state)
      IDLE: begin
        if (gnt_ahb) state_nxt = bus.ahb_we ? AHB_ACK : AHB_RD;
      end
      AHB_RD: begin
        // Read data comes straight from DM in the ack cycle, then is held.
        bus.ahb_rdata = bus.mem_dout;
        state_nxt     = AHB_ACK;
      end
      AHB_ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      last_addr    <= '0;
      last_din     <= '0;
      ahb_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
      ahb_ack_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      ahb_ack_q    <= gnt_ahb;
      cpu_rvalid_q <= gnt_cpu & ~bus.cpu_we;
      if (state == AHB_RD) ahb_rdata_q <= bus.mem_dout;
      if (cpu_rvalid_q) cpu_rdata_q <= bus.mem_dout;
      if (gnt_ahb | gnt_cpu) begin
        last_addr <= bus.mem_addr;
        last_din  <= bus.mem_din;
      end
      // Only cycles where the AHB side was actually eligible count as waiting.
      if (gnt_ahb | ~bus.ahb_req) wait_cnt <= '0;
      else if (ahb_free && (wait_cnt != WAIT_SAT)) wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef DM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
    end else if (bus.cpu_req & bus.ahb_req & ahb_free & (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign bus.conflict_cnt = conflict_q;
`else
  assign bus.conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int MAX_WAIT = 4;
`ifdef DM_ARB_CONFLICT_CNT_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  typedef struct {
    logic          rst;
    logic          cr, cwe;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          ar, awe;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          tab;
    logic          e_stall, e_wen, e_ack, e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_ardata, e_crdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dm_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [DW-1:0] ram [0:2047];
  always @(posedge clk) begin
    if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: transaction-level view of the arbitration rules.
  logic [DW-1:0] ref_mem [0:2047];
  int            m_busy, m_waited, m_conf;
  bit            m_ack, m_ack_rd, m_rv, m_gc, m_ack_now;
  logic [DW-1:0] m_ack_data, m_rv_data, m_ahb_hold, m_cpu_hold, m_last_din;
  logic [AW-1:0] m_last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_waited = 0; m_conf = 0;
    m_ack = 0; m_ack_rd = 0; m_rv = 0;
    m_ack_data = '0; m_rv_data = '0; m_ahb_hold = '0; m_cpu_hold = '0;
    m_last_din = '0; m_last_addr = '0;
  endtask

  task automatic drive_idle();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ahb_req = 0; bus.ahb_we = 0; bus.ahb_addr = '0; bus.ahb_wdata = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  // One clock cycle: drive, compare at negedge, advance model.
  task automatic cycle(input vec_t v);
    bit free, ga, gc;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    rst = v.rst;
    bus.cpu_req = v.cr; bus.cpu_we = v.cwe; bus.cpu_addr = v.ca; bus.cpu_wdata = v.cd;
    bus.ahb_req = v.ar; bus.ahb_we = v.awe; bus.ahb_addr = v.aa; bus.ahb_wdata = v.ad;
    @(negedge clk);
    free = (m_busy == 0);
    ga = v.ar && free && (!v.cr || m_waited >= MAX_WAIT);
    gc = v.cr && !ga;
    e_addr = ga ? v.aa : (gc ? v.ca : m_last_addr);
    e_din  = ga ? v.ad : (gc ? v.cd : m_last_din);
    chk("cpu_stall", bus.cpu_stall, v.cr && !gc);
    chk("mem_wen", bus.mem_wen, (ga && v.awe) || (gc && v.cwe));
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_din", bus.mem_din, e_din);
    chk("ahb_ack", bus.ahb_ack, m_ack);
    chk("ahb_rdata", bus.ahb_rdata, m_ack_rd ? m_ack_data : m_ahb_hold);
    chk("cpu_rvalid", bus.cpu_rvalid, m_rv);
    chk("cpu_rdata", bus.cpu_rdata, m_rv ? m_rv_data : m_cpu_hold);
    chk("conflict_cnt", bus.conflict_cnt, m_conf);
    if (v.tab) begin
      chk("tab_stall", bus.cpu_stall, v.e_stall);
      chk("tab_wen", bus.mem_wen, v.e_wen);
      chk("tab_addr", bus.mem_addr, v.e_addr);
      chk("tab_ack", bus.ahb_ack, v.e_ack);
      chk("tab_rvalid", bus.cpu_rvalid, v.e_rv);
      chk("tab_ahb_rdata", bus.ahb_rdata, v.e_ardata);
      chk("tab_cpu_rdata", bus.cpu_rdata, v.e_crdata);
    end
    m_gc = gc;
    m_ack_now = m_ack;
    if (v.rst) begin
      model_reset();
    end else begin
      if (m_rv) m_cpu_hold = m_rv_data;
      if (m_ack_rd) m_ahb_hold = m_ack_data;
      if (CONF_EN && v.cr && v.ar && free && m_conf < 65535) m_conf++;
      if (ga || !v.ar) m_waited = 0;
      else if (free && m_waited < 15) m_waited++;
      m_ack = ga;
      m_ack_rd = ga && !v.awe;
      m_ack_data = ref_mem[v.aa];
      m_rv = gc && !v.cwe;
      m_rv_data = ref_mem[v.ca];
      if (ga) m_busy = v.awe ? 1 : 2;
      else if (m_busy > 0) m_busy--;
      if (ga || gc) begin m_last_addr = e_addr; m_last_din = e_din; end
      if (ga && v.awe) ref_mem[v.aa] = v.ad;
      if (gc && v.cwe) ref_mem[v.ca] = v.cd;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t V(
    input logic [31:0] cr, cwe, ca, cd, ar, awe, aa, ad,
    input logic [31:0] es, ew, eaddr, eack, erv, eard, ecrd);
    vec_t v;
    v.rst = 0; v.tab = 1;
    v.cr = cr[0]; v.cwe = cwe[0]; v.ca = AW'(ca); v.cd = cd;
    v.ar = ar[0]; v.awe = awe[0]; v.aa = AW'(aa); v.ad = ad;
    v.e_stall = es[0]; v.e_wen = ew[0]; v.e_addr = AW'(eaddr);
    v.e_ack = eack[0]; v.e_rv = erv[0]; v.e_ardata = eard; v.e_crdata = ecrd;
    return v;
  endfunction

  function automatic vec_t R(input bit r, input bit cr, input bit cwe, input int ca,
                             input bit ar, input bit awe, input int aa);
    vec_t v;
    v = V(cr, cwe, ca, 0, ar, awe, aa, 0, 0, 0, 0, 0, 0, 0, 0);
    v.rst = r;
    v.tab = 0;
    return v;
  endfunction

  vec_t tab [21];
  vec_t v;
  bit c_act, c_we, a_act, a_we;
  logic [AW-1:0] c_addr, a_addr;
  logic [DW-1:0] c_wd, a_wd;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    do_reset();

    // Reset values with both sides idle
    chk("rst_cpu_stall", bus.cpu_stall, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_ahb_ack", bus.ahb_ack, 0);
    chk("rst_ahb_rdata", bus.ahb_rdata, 0);
    chk("rst_mem_wen", bus.mem_wen, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_din", bus.mem_din, 0);
    chk("rst_conflict", bus.conflict_cnt, 0);

    //            cr cwe ca      cd    ar awe aa      ad           st wen addr    ack rv ahb_rdata    cpu_rdata
    tab[0]  = V(0, 0, 0,      0,    1, 1, 'h010, 'hDEADBEEF, 0, 1, 'h010, 0, 0, 0,           0);
    tab[1]  = V(0, 0, 0,      0,    1, 1, 'h010, 'hDEADBEEF, 0, 0, 'h010, 1, 0, 0,           0);
    tab[2]  = V(0, 0, 0,      0,    0, 0, 0,     0,          0, 0, 'h010, 0, 0, 0,           0);
    tab[3]  = V(0, 0, 0,      0,    1, 0, 'h010, 0,          0, 0, 'h010, 0, 0, 0,           0);
    tab[4]  = V(0, 0, 0,      0,    1, 0, 'h010, 0,          0, 0, 'h010, 1, 0, 'hDEADBEEF, 0);
    tab[5]  = V(0, 0, 0,      0,    0, 0, 0,     0,          0, 0, 'h010, 0, 0, 'hDEADBEEF, 0);
    tab[6]  = V(1, 0, 'h010,  0,    0, 0, 0,     0,          0, 0, 'h010, 0, 0, 'hDEADBEEF, 0);
    tab[7]  = V(0, 0, 0,      0,    0, 0, 0,     0,          0, 0, 'h010, 0, 1, 'hDEADBEEF, 'hDEADBEEF);
    tab[8]  = V(0, 0, 0,      0,    0, 0, 0,     0,          0, 0, 'h010, 0, 0, 'hDEADBEEF, 'hDEADBEEF);
    tab[9]  = V(1, 0, 'h001,  0,    1, 0, 'h010, 0,          0, 0, 'h001, 0, 0, 'hDEADBEEF, 'hDEADBEEF);
    tab[10] = V(1, 0, 'h001,  0,    1, 0, 'h010, 0,          0, 0, 'h001, 0, 1, 'hDEADBEEF, 0);
    tab[11] = V(1, 0, 'h001,  0,    1, 0, 'h010, 0,          0, 0, 'h001, 0, 1, 'hDEADBEEF, 0);
    tab[12] = V(1, 0, 'h001,  0,    1, 0, 'h010, 0,          0, 0, 'h001, 0, 1, 'hDEADBEEF, 0);
    tab[13] = V(1, 0, 'h001,  0,    1, 0, 'h010, 0,          1, 0, 'h010, 0, 1, 'hDEADBEEF, 0);
    tab[14] = V(1, 0, 'h001,  0,    1, 0, 'h010, 0,          0, 0, 'h001, 1, 0, 'hDEADBEEF, 0);
    tab[15] = V(0, 0, 0,      0,    0, 0, 0,     0,          0, 0, 'h001, 0, 1, 'hDEADBEEF, 0);
    tab[16] = V(1, 1, 'h020, 'h11,  1, 0, 'h020, 0,          0, 1, 'h020, 0, 0, 'hDEADBEEF, 0);
    tab[17] = V(0, 0, 0,      0,    1, 0, 'h020, 0,          0, 0, 'h020, 0, 0, 'hDEADBEEF, 0);
    tab[18] = V(0, 0, 0,      0,    1, 0, 'h020, 0,          0, 0, 'h020, 1, 0, 'h11,       0);
    tab[19] = V(0, 0, 0,      0,    0, 0, 0,     0,          0, 0, 'h020, 0, 0, 'h11,       0);
    tab[20] = V(0, 0, 0,      0,    0, 0, 0,     0,          0, 0, 'h020, 0, 0, 'h11,       0);
    for (int i = 0; i < 21; i++) cycle(tab[i]);

    // Reset while an AHB read is in AHB_RD: ack must not reappear
    cycle(R(0, 0, 0, 0, 1, 0, 'h020));
    cycle(R(1, 0, 0, 0, 1, 0, 'h020));
    cycle(R(0, 0, 0, 0, 0, 0, 0));
    chk("rstmid_ahb_ack", bus.ahb_ack, 0);
    chk("rstmid_ahb_rdata", bus.ahb_rdata, 0);
    chk("rstmid_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rstmid_cpu_rdata", bus.cpu_rdata, 0);
    chk("rstmid_mem_addr", bus.mem_addr, 0);
    chk("rstmid_mem_din", bus.mem_din, 0);
    chk("rstmid_mem_wen", bus.mem_wen, 0);
    // Back in IDLE: a fresh AHB write is granted immediately
    cycle(R(0, 0, 0, 0, 1, 1, 'h030));

    // Contention: 10 cycles of both requests, counted only while AHB is free
    do_reset();
    for (int i = 0; i < 10; i++) cycle(R(0, 1, 0, 'h003, 1, 0, 'h004));
    cycle(R(0, 0, 0, 0, 0, 0, 0));
    chk("conflict_10", bus.conflict_cnt, CONF_EN ? 8 : 0);

    // Randomized traffic against the reference model
    c_act = 0; a_act = 0;
    c_we = 0; a_we = 0; c_addr = '0; a_addr = '0; c_wd = '0; a_wd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!c_act && $urandom_range(0, 2) == 0) begin
        c_act = 1; c_we = 1'($urandom_range(0, 1));
        c_addr = AW'($urandom_range(0, 7)); c_wd = $urandom;
      end
      if (!a_act && $urandom_range(0, 3) == 0) begin
        a_act = 1; a_we = 1'($urandom_range(0, 1));
        a_addr = AW'($urandom_range(0, 7)); a_wd = $urandom;
      end
      v = R(0, c_act, c_we, int'(c_addr), a_act, a_we, int'(a_addr));
      v.cd = c_wd;
      v.ad = a_wd;
      cycle(v);
      if (m_gc) c_act = 0;
      if (m_ack_now) a_act = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
